if_id_pipe_reg: RTL and testbench
=================================

# if_id_pipe_reg

Parametrised, clocked IF/ID pipeline register between the fetch stage and the decode stage. It carries the fetched instruction and its next-PC value under a valid/ready handshake, with stall (backpressure) and flush (bubble insertion) support. An optional skid buffer registers the upstream ready so the stall path never runs combinationally from decode back to fetch.

## Interface
- `INSTR_W`, default 32: instruction width.
- `PC_W`, default 32: next-PC width.
- `NOP_INSTR`, default `32'h0000_0000`: value driven on `instruction_out` when no valid entry is held. Must be `INSTR_W` bits wide.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  register can accept this cycle.
- `instruction_in`  in  `INSTR_W`  fetched instruction.
- `npc_in`  in  `PC_W`  PC+4 of the fetched instruction.
- `flush`  in  1  synchronous squash of all held entries (branch/jump taken).
- `out_valid`  out  1  decode-side entry valid.
- `out_ready`  in  1  decode consumes this cycle.
- `instruction_out`  out  `INSTR_W`  held instruction, or `NOP_INSTR`.
- `npc_out`  out  `PC_W`  held next-PC, or 0.

## Operation
- Transfers: upstream fires when `in_valid && in_ready`; downstream fires when `out_valid && out_ready`.
- Data is never reordered, duplicated or dropped, except by `flush`.
- While `out_valid=0`, `instruction_out = NOP_INSTR` and `npc_out = 0`. Decode sees a bubble.
- Flush:
  - A `flush=1` sampled at the edge clears every entry.
  - The next cycle has `out_valid=0` and NOP outputs.
  - Any upstream transfer in the same cycle is discarded.
  - `flush` has priority over all other events.
- Output registers hold their value while `out_valid && !out_ready` (stall).
- Skid mode states (see Configuration):
  - EMPTY: nothing held. An upstream fire goes to ONE.
  - ONE: main register valid.
    - Upstream fire with downstream fire: stays ONE, main reloads.
    - Upstream fire without downstream fire: goes to FULL, data lands in skid.
    - Downstream fire only: goes to EMPTY.
  - FULL: main and skid valid, `in_ready=0`. A downstream fire moves skid into main and goes to ONE.
  - Flush from any state goes to EMPTY.

## Timing
- Latency: data accepted at edge N is visible on the outputs after edge N (one cycle).
- Throughput: one transfer per cycle while `out_ready=1`.
- Reset values (asynchronous, during `rst_n=0`):
  - `out_valid=0`, `instruction_out=NOP_INSTR`, `npc_out=0`.
  - Skid state EMPTY, `in_ready=1`.
- Reset asserted mid-transfer discards all held entries immediately, with no wait for `clk`.
- Upstream data and valid must stay stable until accepted. The block does not check this.
- `flush` together with `out_ready=0`: entries are still cleared, so `out_valid=0` next cycle.

## Configuration
- `IF_ID_SKID_EN` defined:
  - Two entries (main + skid).
  - `in_ready` is a flop equal to "skid empty".
  - No combinational path from `out_ready` to `in_ready`.
- `IF_ID_SKID_EN` undefined:
  - Single entry.
  - `in_ready = !out_valid || out_ready`, which is combinational from `out_ready`.
  - The FULL state does not exist.
- All other behaviour is identical in both builds, including reset, flush and NOP output.

## Structure
- Shared package `pipe_pkg`:
  - Default `NOP_INSTR` constant.
  - Skid-state enum: `EMPTY`, `ONE`, `FULL`.
  - Entry struct `{instr, npc}` typedef built from the width parameters.
- One natural sub-module: `pipe_skid_buf`. It is the generic two-entry skid storage plus its state machine, instantiated only when `IF_ID_SKID_EN` is defined.

## Test plan
- Reset: hold `rst_n=0` with `in_valid=1`, `instruction_in=32'h2008_0005`. Required: `out_valid=0`, `instruction_out=NOP_INSTR`, `npc_out=0`, `in_ready=1`.
- Streaming: send 4 instructions (`0x1000..0x1003`, npc `0x4..0x10`) with `out_ready=1`. Required: each appears exactly one cycle later, in order, with no gaps.
- Stall: accept `0xAAAA_0001`, then hold `out_ready=0` for 3 cycles while offering `0xAAAA_0002`.
  - Outputs stay at `0xAAAA_0001`.
  - Skid build: second word is held in skid, then `in_ready=0`.
  - Non-skid build: `in_ready=0` immediately.
  - After release, both words emerge in order.
- Flush in FULL: fill main and skid, then assert `flush` with `in_valid=1` and `instruction_in=0xBBBB_0003`. Required: next cycle `out_valid=0`, NOP outputs, `0xBBBB_0003` never appears.
- Async reset mid-stall: drop `rst_n` between clock edges while FULL. Required: outputs go to reset values before the next `clk` edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the fetch/decode pipeline registers: default NOP, skid
// occupancy states, default-width entry layout and the skid next-state rule.
package pipe_pkg;

  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned PC_W_DEF    = 32;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [PC_W_DEF-1:0]    npc;
  } if_id_entry_t;

  // Occupancy transition of a two-entry skid buffer; flush always wins.
  function automatic skid_state_e skid_next_state(
    input skid_state_e cur,
    input logic        up_fire,
    input logic        dn_fire,
    input logic        flush
  );
    skid_state_e nxt;
    nxt = cur;
    if (flush) begin
      nxt = EMPTY;
    end else begin
      case (cur)
        EMPTY: begin
          if (up_fire) nxt = ONE;
          else         nxt = EMPTY;
        end
        ONE: begin
          if (up_fire && !dn_fire)      nxt = FULL;
          else if (!up_fire && dn_fire) nxt = EMPTY;
          else                          nxt = ONE;
        end
        FULL: begin
          if (dn_fire) nxt = ONE;
          else         nxt = FULL;
        end
        default: nxt = EMPTY;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer: main register drives the outputs, the skid
// register absorbs one word so in_ready can be a flop.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W    = 64,
  parameter logic [DATA_W-1:0]  EMPTY_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              up_fire_s, dn_fire_s;

  assign up_fire_s = in_valid && in_ready_q;
  assign dn_fire_s = out_valid_q && out_ready;

  // Next state and data movement; main holds EMPTY_VAL whenever nothing is held.
  always_comb begin
    state_d     = skid_next_state(state_q, up_fire_s, dn_fire_s, flush);
    main_d      = main_q;
    skid_d      = skid_q;
    if (state_d == EMPTY) begin
      main_d = EMPTY_VAL;
    end else if (state_q == FULL && dn_fire_s) begin
      main_d = skid_q;
    end else if (up_fire_s && (state_q == EMPTY || dn_fire_s)) begin
      main_d = in_data;
    end else begin
      main_d = main_q;
    end
    if (state_q == ONE && state_d == FULL) begin
      skid_d = in_data;
    end else begin
      skid_d = skid_q;
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  // State machine and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= EMPTY_VAL;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid/ready, stall and flush. Defining
// IF_ID_SKID_EN adds a skid entry so in_ready is registered.
module if_id_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        INSTR_W   = 32,
  parameter int unsigned        PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction_in,
  input  logic [PC_W-1:0]    npc_in,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [PC_W-1:0]    npc_out
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    npc;
  } entry_t;

  localparam entry_t EMPTY_ENTRY = '{instr: NOP_INSTR, npc: {PC_W{1'b0}}};

  entry_t in_entry_s;
  entry_t out_entry_s;

  assign in_entry_s = {instruction_in, npc_in};

`ifdef IF_ID_SKID_EN

  pipe_skid_buf #(
    .DATA_W    ($bits(entry_t)),
    .EMPTY_VAL (EMPTY_ENTRY)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_entry_s)
  );

`else

  entry_t entry_q, entry_d;
  logic   valid_q, valid_d;
  logic   up_fire_s, dn_fire_s;

  // Single entry: a held word can be replaced in the same cycle it drains.
  assign in_ready  = !valid_q || out_ready;
  assign up_fire_s = in_valid && in_ready;
  assign dn_fire_s = valid_q && out_ready;

  // Flush beats an upstream load, which beats a plain drain.
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush) begin
      valid_d = 1'b0;
      entry_d = EMPTY_ENTRY;
    end else if (up_fire_s) begin
      valid_d = 1'b1;
      entry_d = in_entry_s;
    end else if (dn_fire_s) begin
      valid_d = 1'b0;
      entry_d = EMPTY_ENTRY;
    end else begin
      valid_d = valid_q;
      entry_d = entry_q;
    end
  end

  // Output entry register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      entry_q <= EMPTY_ENTRY;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_entry_s = entry_q;

`endif

  assign instruction_out = out_entry_s.instr;
  assign npc_out         = out_entry_s.npc;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg; expectations adapt to IF_ID_SKID_EN.
module tb_if_id_pipe_reg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction_in;
  logic [31:0] npc_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction_out;
  logic [31:0] npc_out;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_id_pipe_reg #(
    .INSTR_W   (32),
    .PC_W      (32),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .instruction_in  (instruction_in),
    .npc_in          (npc_in),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .instruction_out (instruction_out),
    .npc_out         (npc_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] npc);
    chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, "_instr"}, instruction_out, ins);
    chk({tag, "_npc"}, npc_out, npc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] npc);
    in_valid       = 1'b1;
    instruction_in = ins;
    npc_in         = npc;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    offer(32'h2008_0005, 32'h0000_0004);
    tick;
    tick;
    chk_out("reset", 1'b0, NOP, 32'h0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(32'h0000_1000 + 32'(i), 32'h0000_0004 + 32'(4 * i));
      #1;
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      tick;
      chk_out("stream", 1'b1, 32'h0000_1000 + 32'(i), 32'h0000_0004 + 32'(4 * i));
    end
    in_valid = 1'b0;
    tick;
    chk_out("stream_drain", 1'b0, NOP, 32'h0);

    offer(32'hAAAA_0001, 32'h0000_0100);
    tick;
    chk_out("stall_first", 1'b1, 32'hAAAA_0001, 32'h0000_0100);
    out_ready = 1'b0;
    offer(32'hAAAA_0002, 32'h0000_0104);
    #1;
`ifdef IF_ID_SKID_EN
    chk("stall_in_ready_pre", {31'd0, in_ready}, 32'd1);
`else
    chk("stall_in_ready_pre", {31'd0, in_ready}, 32'd0);
`endif
    for (int k = 0; k < 3; k++) begin
      tick;
`ifdef IF_ID_SKID_EN
      if (k == 0) in_valid = 1'b0;
`endif
      chk_out("stall_hold", 1'b1, 32'hAAAA_0001, 32'h0000_0100);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
`ifdef IF_ID_SKID_EN
    chk("release_in_ready", {31'd0, in_ready}, 32'd0);
`else
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
`endif
    tick;
    in_valid = 1'b0;
    chk_out("release_second", 1'b1, 32'hAAAA_0002, 32'h0000_0104);
    chk("release_in_ready_post", {31'd0, in_ready}, 32'd1);
    tick;
    chk_out("release_drain", 1'b0, NOP, 32'h0);

    offer(32'hC000_0001, 32'h0000_0200);
    tick;
    out_ready = 1'b0;
`ifdef IF_ID_SKID_EN
    offer(32'hC000_0002, 32'h0000_0204);
    tick;
    chk("fill_full_in_ready", {31'd0, in_ready}, 32'd0);
`endif
    chk_out("fill_main", 1'b1, 32'hC000_0001, 32'h0000_0200);
    offer(32'hBBBB_0003, 32'h0000_0208);
    flush = 1'b1;
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_out("flush_full", 1'b0, NOP, 32'h0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick;
    chk_out("flush_no_leak", 1'b0, NOP, 32'h0);

    offer(32'hBBBB_0004, 32'h0000_020C);
    flush = 1'b1;
    #1;
    chk("flush_up_in_ready", {31'd0, in_ready}, 32'd1);
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_out("flush_discard_up", 1'b0, NOP, 32'h0);
    tick;
    chk_out("flush_discard_up2", 1'b0, NOP, 32'h0);

    offer(32'hDDDD_0001, 32'h0000_0300);
    tick;
    chk_out("recover", 1'b1, 32'hDDDD_0001, 32'h0000_0300);
    out_ready = 1'b0;
`ifdef IF_ID_SKID_EN
    offer(32'hDDDD_0002, 32'h0000_0304);
    tick;
    chk("arst_full_in_ready", {31'd0, in_ready}, 32'd0);
`endif
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("arst_async", 1'b0, NOP, 32'h0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    tick;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick;
    chk_out("arst_after", 1'b0, NOP, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
